// File: rtl/hash_ctrl_pkg.sv
// Shared types for the hash job/timer controller: FSM states, end-of-job
// causes and the cause priority encoder.
package hash_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_REPORT
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_FOUND   = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_EXHAUST = 2'd2,
    CAUSE_ABORT   = 2'd3
  } cause_t;

  // Several end events can land in the same cycle; abort wins, then a found
  // nonce, then exhaustion, and timeout only when nothing else happened.
  function automatic cause_t pick_cause(input logic abort_ev,
                                        input logic found_ev,
                                        input logic exhaust_ev);
    if (abort_ev)        return CAUSE_ABORT;
    else if (found_ev)   return CAUSE_FOUND;
    else if (exhaust_ev) return CAUSE_EXHAUST;
    else                 return CAUSE_TIMEOUT;
  endfunction

endpackage

// File: rtl/hash_job_timer_ctrl_usec_prescaler.sv
// usec_prescaler: divides clk down to a one-cycle strobe every CLK_PER_USEC
// enabled cycles. clear restarts the count at 0 and wins over enable.
module usec_prescaler #(
  parameter int CLK_PER_USEC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic stb
);

  localparam int CW = (CLK_PER_USEC > 1) ? $clog2(CLK_PER_USEC) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_PER_USEC - 1);

  logic [CW-1:0] cnt_q;

  // Strobe is combinational so the usec counter bumps in the terminal cycle.
  assign stb = en && (cnt_q == TERM);

  // Free-running modulo counter while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (en)     cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/hash_job_timer_ctrl.sv
// hash_job_timer_ctrl: runs one nonce-search job on the hash core, times it
// in microseconds, and hands a result record to the dispatcher.
// Optional build macro HASH_JOB_STATS_EN adds job/timeout statistics outputs.
module hash_job_timer_ctrl
  import hash_ctrl_pkg::*;
#(
  parameter int CLK_PER_USEC = 100,
  parameter int NONCE_W      = 32,
  parameter int TIME_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_start,
  input  logic [TIME_W-1:0]  timeout_us,
  input  logic               job_abort,
  input  logic               nonce_done,
  input  logic               golden_found,
  output logic               core_en,
  output logic               core_tick,
  output logic               busy,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [1:0]         rpt_cause,
  output logic [NONCE_W-1:0] rpt_nonces,
  output logic [TIME_W-1:0]  rpt_usec
`ifdef HASH_JOB_STATS_EN
  ,
  output logic [15:0]        stat_jobs,
  output logic [15:0]        stat_timeouts
`endif
);

  state_t               state_q, state_d;
  logic [TIME_W-1:0]    limit_q, usec_q, usec_d;
  logic [NONCE_W-1:0]   nonces_q, nonces_d;
  logic                 tick_q;
  cause_t               cause_q;
  logic                 usec_stb, run, job_accept, xfer;
  logic                 usec_inc, nonce_inc;
  logic                 ev_abort, ev_found, ev_exhaust, ev_timeout, job_end;

  assign run        = (state_q == ST_RUN);
  assign job_accept = (state_q == ST_IDLE) && job_start;
  assign xfer       = (state_q == ST_REPORT) && rpt_ready;

  usec_prescaler #(.CLK_PER_USEC(CLK_PER_USEC)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (job_accept),
    .en    (run),
    .stb   (usec_stb)
  );

  // Saturating next values; the report captures these so an end event sees
  // its own cycle's increments.
  assign usec_inc   = run && usec_stb && !(&usec_q);
  assign nonce_inc  = run && nonce_done && !(&nonces_q);
  assign usec_d     = usec_q + TIME_W'(usec_inc);
  assign nonces_d   = nonces_q + NONCE_W'(nonce_inc);

  assign ev_abort   = run && job_abort;
  assign ev_found   = run && golden_found;
  assign ev_exhaust = run && nonce_done && (&nonces_q);
  // Timeout fires only on the step that lands on the limit, never when saturated.
  assign ev_timeout = usec_inc && (limit_q != '0) && (usec_d == limit_q);
  assign job_end    = ev_abort || ev_found || ev_exhaust || ev_timeout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    core_en   = 1'b0;
    busy      = 1'b0;
    rpt_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        core_en = 1'b1;
        busy    = 1'b1;
        if (job_end) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        busy      = 1'b1;
        rpt_valid = 1'b1;
        if (rpt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job counters: cleared on accept, advance only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q  <= '0;
      usec_q   <= '0;
      nonces_q <= '0;
    end else if (job_accept) begin
      limit_q  <= timeout_us;
      usec_q   <= '0;
      nonces_q <= '0;
    end else if (run) begin
      usec_q   <= usec_d;
      nonces_q <= nonces_d;
    end
  end

  // One-cycle clear pulse to the shared time counter, first RUN cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= job_accept;
  end

  assign core_tick = tick_q;

  // Report record loads once at job end and holds through the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q    <= CAUSE_FOUND;
      rpt_nonces <= '0;
      rpt_usec   <= '0;
    end else if (job_end) begin
      cause_q    <= pick_cause(ev_abort, ev_found, ev_exhaust);
      rpt_nonces <= nonces_d;
      rpt_usec   <= usec_d;
    end
  end

  assign rpt_cause = cause_q;

`ifdef HASH_JOB_STATS_EN
  // Handshake statistics, wrapping, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_jobs     <= '0;
      stat_timeouts <= '0;
    end else if (xfer) begin
      stat_jobs <= stat_jobs + 16'd1;
      if (cause_q == CAUSE_TIMEOUT) stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_job_timer_ctrl.sv
// Bench for hash_job_timer_ctrl: table of whole-job vectors, hand sequences
// for back-pressure and reset, and random jobs against a job-level model.
module tb_hash_job_timer_ctrl;

  localparam int CPU = 4;
  localparam int NW  = 4;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_start = 1'b0;
  logic [TW-1:0] timeout_us = '0;
  logic          job_abort = 1'b0;
  logic          nonce_done = 1'b0;
  logic          golden_found = 1'b0;
  logic          rpt_ready = 1'b0;
  logic          core_en, core_tick, busy, rpt_valid;
  logic [1:0]    rpt_cause;
  logic [NW-1:0] rpt_nonces;
  logic [TW-1:0] rpt_usec;
`ifdef HASH_JOB_STATS_EN
  logic [15:0]   stat_jobs, stat_timeouts;
`endif

  int total = 0;
  int bad   = 0;

  hash_job_timer_ctrl #(.CLK_PER_USEC(CPU), .NONCE_W(NW), .TIME_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .timeout_us(timeout_us),
    .job_abort(job_abort), .nonce_done(nonce_done), .golden_found(golden_found),
    .core_en(core_en), .core_tick(core_tick), .busy(busy), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_cause(rpt_cause), .rpt_nonces(rpt_nonces),
    .rpt_usec(rpt_usec)
`ifdef HASH_JOB_STATS_EN
    , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tmo;
    int pulses;    // nonce_done asserted in RUN cycles 1..pulses
    int gold_at;   // RUN cycle with golden_found (0 = never)
    int abort_at;  // RUN cycle with job_abort (0 = never)
    int cause;
    int nonces;
    int usec;
    int lat;       // cycles from core_tick to rpt_valid
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    job_start = 0; nonce_done = 0; golden_found = 0; job_abort = 0;
  endtask

  // Pulse job_start from IDLE; returns positioned in the first RUN cycle.
  task automatic start_job(input int tmo);
    @(negedge clk);
    job_start  = 1'b1;
    timeout_us = TW'(tmo);
    @(negedge clk);
    job_start  = 1'b0;
    chk("core_tick_first", core_tick, 1);
    chk("core_en_run", core_en, 1);
  endtask

  task automatic handshake();
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
    chk("valid_after_xfer", rpt_valid, 0);
    chk("busy_after_xfer", busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0;
    start_job(v.tmo);
    for (int k = 1; k <= 1500; k++) begin
      nonce_done   = (k <= v.pulses);
      golden_found = (k == v.gold_at);
      job_abort    = (k == v.abort_at);
      @(negedge clk);
      clr_inputs();
      if (k == 1 && !rpt_valid) chk("core_tick_once", core_tick, 0);
      if (rpt_valid) begin lat = k; break; end
    end
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_cause", idx), rpt_cause, v.cause);
    chk($sformatf("v%0d_nonces", idx), rpt_nonces, v.nonces);
    chk($sformatf("v%0d_usec", idx), rpt_usec, v.usec);
    chk($sformatf("v%0d_core_en_off", idx), core_en, 0);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    handshake();
  endtask

  // Random jobs; the model sees the job as elapsed RUN cycles k (usec is
  // k/CPU, saturating) plus a count of nonce pulses.
  task automatic rand_jobs(input int njobs);
    for (int j = 0; j < njobs; j++) begin
      int tmo, n, ecause, eusec;
      bit done, nd, g, a;
      logic [1:0] c0; logic [NW-1:0] n0; logic [TW-1:0] u0;
      tmo  = $urandom_range(0, 4);
      n    = 0;
      done = 0;
      start_job(tmo);
      for (int k = 1; k <= 300 && !done; k++) begin
        nd = ($urandom_range(0, 2) == 0);
        g  = ($urandom_range(0, 39) == 0);
        a  = ($urandom_range(0, 59) == 0);
        nonce_done = nd; golden_found = g; job_abort = a;
        if (a)                                          ecause = 3;
        else if (g)                                     ecause = 0;
        else if (nd && n == (1 << NW) - 1)              ecause = 2;
        else if (tmo != 0 && k % CPU == 0 && k / CPU == tmo) ecause = 1;
        else                                            ecause = -1;
        if (nd && n < (1 << NW) - 1) n++;
        eusec = (k / CPU > 255) ? 255 : k / CPU;
        @(negedge clk);
        clr_inputs();
        chk("rnd_valid", rpt_valid, ecause >= 0);
        if (ecause >= 0) begin
          done = 1;
          chk("rnd_cause", rpt_cause, ecause);
          chk("rnd_nonces", rpt_nonces, n);
          chk("rnd_usec", rpt_usec, eusec);
        end
      end
      chk("rnd_job_ended", done, 1);
      c0 = rpt_cause; n0 = rpt_nonces; u0 = rpt_usec;
      repeat ($urandom_range(0, 3)) begin
        nonce_done = $urandom_range(0, 1);
        @(negedge clk);
        nonce_done = 0;
        chk("rnd_hold", {rpt_valid, rpt_cause, rpt_nonces, rpt_usec}, {1'b1, c0, n0, u0});
      end
      handshake();
    end
  endtask

  initial begin
    //           tmo pulses gold abort cause nonces usec lat
    vecs[0] = '{3,   0,     0,   0,    1,    0,     3,   12};
    vecs[1] = '{0,   6,     6,   0,    0,    6,     1,   6};
    vecs[2] = '{0,   2,     2,   2,    3,    2,     0,   2};
    vecs[3] = '{0,   16,    0,   0,    2,    15,    4,   16};
    vecs[4] = '{2,   3,     0,   0,    1,    3,     2,   8};
    vecs[5] = '{4,   16,    0,   0,    2,    15,    4,   16};
    vecs[6] = '{0,   0,     0,   1100, 3,    0,     255, 1100};

    // Reset state
    #2;
    chk("rst_core_en", core_en, 0);
    chk("rst_core_tick", core_tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rpt_valid, 0);
    chk("rst_record", {rpt_cause, rpt_nonces, rpt_usec}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Whole-job vectors
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
`ifdef HASH_JOB_STATS_EN
      if (i == 1) begin
        chk("stat_jobs", stat_jobs, 2);
        chk("stat_timeouts", stat_timeouts, 1);
      end
`endif
    end

    // Back-pressure: record frozen, busy held, job_start ignored
    begin
      int lat = 0;
      logic [1:0] c0; logic [NW-1:0] n0; logic [TW-1:0] u0;
      start_job(1);
      for (int k = 1; k <= 20; k++) begin
        nonce_done = (k <= 2);
        @(negedge clk);
        clr_inputs();
        if (rpt_valid) begin lat = k; break; end
      end
      chk("bp_lat", lat, 4);
      c0 = rpt_cause; n0 = rpt_nonces; u0 = rpt_usec;
      chk("bp_record", {c0, n0, u0}, {2'd1, 4'd2, 8'd1});
      for (int k = 0; k < 10; k++) begin
        job_start = 1; nonce_done = 1; job_abort = 1; golden_found = k[0];
        @(negedge clk);
        clr_inputs();
        chk("bp_hold", {rpt_valid, busy, core_en, core_tick, rpt_cause, rpt_nonces, rpt_usec},
            {1'b1, 1'b1, 1'b0, 1'b0, c0, n0, u0});
      end
      handshake();
      // Minimum turnaround: accepted the cycle after the handshake
      start_job(0);
      job_abort = 1;
      @(negedge clk);
      clr_inputs();
      chk("turn_valid", rpt_valid, 1);
      chk("turn_record", {rpt_cause, rpt_nonces, rpt_usec}, {2'd3, 4'd0, 8'd0});
      handshake();
    end

    rand_jobs(30);

    // Reset mid-run drops outputs without waiting for a clock edge
    start_job(0);
    repeat (3) begin
      nonce_done = 1;
      @(negedge clk);
    end
    nonce_done = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core_en", core_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_outputs", {core_tick, rpt_valid, rpt_cause, rpt_nonces, rpt_usec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
